// File: rtl/pipe_pkg.sv
// Shared pipeline bundle layouts for the EX/MEM and MEM/WB boundaries.
// Field positions are kept here so every stage slices the bundles identically.
package pipe_pkg;

   localparam int DATA_W     = 16;
   localparam int REG_ADDR_W = 3;
   localparam int EX_MEM_W   = 38;
   localparam int MEM_WB_W   = 20;

   localparam int ALU_MSB = 37;
   localparam int ALU_LSB = 22;
   localparam int MWE_BIT = 21;
   localparam int MWD_MSB = 20;
   localparam int MWD_LSB = 5;
   localparam int WBE_BIT = 4;
   localparam int DST_MSB = 3;
   localparam int DST_LSB = 1;
   localparam int SEL_BIT = 0;

   localparam int WBD_MSB     = 19;
   localparam int WBD_LSB     = 4;
   localparam int WBE_OUT     = 3;
   localparam int DST_OUT_MSB = 2;

   typedef struct packed {
      logic [DATA_W-1:0]     wb_data;
      logic                  wb_en;
      logic [REG_ADDR_W-1:0] wb_dest;
   } mem_wb_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: combinational read, write on the rising edge.
// Contents are deliberately not reset.
module data_memory
   import pipe_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clock) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

   assign rdata = mem_q[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: multi-cycle load/store with upstream stall,
// write-back select and the registered MEM/WB bundle.
module mem_stage
   import pipe_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int MEM_LATENCY = 1,
   parameter int CNT_W       = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [EX_MEM_W-1:0] ex_mem_in,
   output logic [MEM_WB_W-1:0] mem_wb_out,
   output logic                stall_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_LATENCY - 1);

   logic [DATA_W-1:0]     alu_result;
   logic                  mem_write_en;
   logic [DATA_W-1:0]     mem_write_data;
   logic                  wb_en;
   logic [REG_ADDR_W-1:0] wb_dest;
   logic                  wb_sel;
   logic                  is_store;
   logic                  is_load;
   logic                  access;
   logic                  last_cycle;
   logic                  mem_we;
   logic [DATA_W-1:0]     mem_rdata;
   logic [CNT_W-1:0]      cnt_d, cnt_q;
   mem_wb_t               mem_wb_d, mem_wb_q;

   assign alu_result     = ex_mem_in[ALU_MSB:ALU_LSB];
   assign mem_write_en   = ex_mem_in[MWE_BIT];
   assign mem_write_data = ex_mem_in[MWD_MSB:MWD_LSB];
   assign wb_en          = ex_mem_in[WBE_BIT];
   assign wb_dest        = ex_mem_in[DST_MSB:DST_LSB];
   assign wb_sel         = ex_mem_in[SEL_BIT];

   // A write is gated by reset so a store caught mid-access is abandoned.
   always_comb begin
      is_store   = mem_write_en;
      is_load    = wb_en & wb_sel;
      access     = is_store | is_load;
      last_cycle = (cnt_q == LAST_CNT);
      stall_o    = access & ~last_cycle;
      mem_we     = is_store & last_cycle & reset;

      cnt_d    = '0;
      mem_wb_d = '0;
      if (access && !last_cycle) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         mem_wb_d.wb_data = (access && wb_sel) ? mem_rdata : alu_result;
         mem_wb_d.wb_en   = wb_en;
         mem_wb_d.wb_dest = wb_dest;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q    <= '0;
         mem_wb_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         mem_wb_q <= mem_wb_d;
      end
   end

   assign mem_wb_out = mem_wb_q;

   data_memory #(
      .ADDR_W(ADDR_W)
   ) u_data_memory (
      .clock (clock),
      .we    (mem_we),
      .addr  (alu_result[ADDR_W-1:0]),
      .wdata (mem_write_data),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage with single-cycle and 3-cycle memory.
// Expected MEM/WB words are queued when a bundle is driven and checked after the edge.
module tb_mem_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [37:0] in1   = '0;
   logic [37:0] in3   = '0;
   logic [19:0] out1;
   logic [19:0] out3;
   logic        stall1;
   logic        stall3;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          dut;
      logic [19:0] exp;
      string       tag;
   } sb_t;

   sb_t sb_q[$];

   always #5 clock = ~clock;

   mem_stage #(.ADDR_W(8), .MEM_LATENCY(1), .CNT_W(4)) dut1 (
      .clock      (clock),
      .reset      (reset),
      .ex_mem_in  (in1),
      .mem_wb_out (out1),
      .stall_o    (stall1)
   );

   mem_stage #(.ADDR_W(8), .MEM_LATENCY(3), .CNT_W(4)) dut3 (
      .clock      (clock),
      .reset      (reset),
      .ex_mem_in  (in3),
      .mem_wb_out (out3),
      .stall_o    (stall3)
   );

   function automatic logic [37:0] bundle(input logic [15:0] alu, input logic mwe,
                                          input logic [15:0] mwd, input logic wbe,
                                          input logic [2:0] dst, input logic sel);
      return {alu, mwe, mwd, wbe, dst, sel};
   endfunction

   function automatic logic [19:0] wb(input logic [15:0] d, input logic e, input logic [2:0] dst);
      return {d, e, dst};
   endfunction

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag, input logic [19:0] obs, input logic [19:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%05h expected=%05h", tag, obs, exp);
      end
   endtask

   // Drives one bundle into the chosen instance for one cycle, checks stall
   // before the edge and the queued MEM/WB word after it.
   task automatic apply_stimulus(input int dut, input logic [37:0] b,
                                 input logic [19:0] exp, input logic exp_stall,
                                 input string tag);
      sb_t e;
      if (dut == 1) begin
         in1 = b;
         in3 = '0;
      end else begin
         in3 = b;
         in1 = '0;
      end
      #1;
      check_bit({tag, "_stall"}, (dut == 1) ? stall1 : stall3, exp_stall);
      e.dut = dut;
      e.exp = exp;
      e.tag = tag;
      sb_q.push_back(e);
      @(posedge clock);
      #1;
      check_output();
   endtask

   task automatic check_output();
      sb_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check_word(e.tag, (e.dut == 1) ? out1 : out3, e.exp);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [63:0] rnd;

      reset = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 2; i++) begin
         rnd = {$urandom, $urandom};
         in1 = rnd[37:0];
         rnd = {$urandom, $urandom};
         in3 = rnd[37:0];
         in3[21] = 1'b0;
         in3[4]  = 1'b0;
         @(posedge clock);
         #1;
         check_word("rst_out1", out1, 20'h0);
         check_word("rst_out3", out3, 20'h0);
         check_bit("rst_stall1", stall1, 1'b0);
         check_bit("rst_stall3", stall3, 1'b0);
      end
      reset = 1'b1;

      apply_stimulus(1, bundle(16'h1234, 0, 16'h0, 1, 3'd5, 0), wb(16'h1234, 1, 3'd5), 1'b0, "l1_alu");
      apply_stimulus(1, bundle(16'h0010, 1, 16'hBEEF, 0, 3'd0, 0), wb(16'h0010, 0, 3'd0), 1'b0, "l1_store");
      apply_stimulus(1, bundle(16'h0010, 0, 16'h0, 1, 3'd3, 1), wb(16'hBEEF, 1, 3'd3), 1'b0, "l1_load");
      apply_stimulus(1, bundle(16'h0105, 1, 16'h0F0F, 0, 3'd0, 0), wb(16'h0105, 0, 3'd0), 1'b0, "wrap_store");
      apply_stimulus(1, bundle(16'h0005, 0, 16'h0, 1, 3'd2, 1), wb(16'h0F0F, 1, 3'd2), 1'b0, "wrap_load");
      apply_stimulus(1, bundle(16'h0005, 1, 16'h1111, 1, 3'd1, 1), wb(16'h0F0F, 1, 3'd1), 1'b0, "dual_flag");
      apply_stimulus(1, bundle(16'h0005, 0, 16'h0, 1, 3'd7, 1), wb(16'h1111, 1, 3'd7), 1'b0, "dual_after");
      apply_stimulus(1, bundle(16'h0010, 0, 16'h0, 0, 3'd4, 1), wb(16'h0010, 0, 3'd4), 1'b0, "load_noen");

      apply_stimulus(3, bundle(16'h0004, 1, 16'h5555, 0, 3'd0, 0), 20'h0, 1'b1, "l3_st_c0");
      apply_stimulus(3, bundle(16'h0004, 1, 16'h5555, 0, 3'd0, 0), 20'h0, 1'b1, "l3_st_c1");
      apply_stimulus(3, bundle(16'h0004, 1, 16'h5555, 0, 3'd0, 0), wb(16'h0004, 0, 3'd0), 1'b0, "l3_st_c2");
      apply_stimulus(3, bundle(16'h0004, 0, 16'h0, 1, 3'd6, 1), 20'h0, 1'b1, "l3_ld_c0");
      apply_stimulus(3, bundle(16'h0004, 0, 16'h0, 1, 3'd6, 1), 20'h0, 1'b1, "l3_ld_c1");
      apply_stimulus(3, bundle(16'h0004, 0, 16'h0, 1, 3'd6, 1), wb(16'h5555, 1, 3'd6), 1'b0, "l3_ld_c2");
      apply_stimulus(3, bundle(16'hCAFE, 0, 16'h0, 1, 3'd2, 0), wb(16'hCAFE, 1, 3'd2), 1'b0, "l3_alu");

      apply_stimulus(3, bundle(16'h0004, 1, 16'hAAAA, 0, 3'd0, 0), 20'h0, 1'b1, "abort_c0");
      apply_stimulus(3, bundle(16'h0004, 1, 16'hAAAA, 0, 3'd0, 0), 20'h0, 1'b1, "abort_c1");
      reset = 1'b0;
      apply_stimulus(3, bundle(16'h0004, 1, 16'hAAAA, 0, 3'd0, 0), 20'h0, 1'b0, "abort_rst");
      reset = 1'b1;
      apply_stimulus(3, bundle(16'h0004, 0, 16'h0, 1, 3'd6, 1), 20'h0, 1'b1, "after_c0");
      apply_stimulus(3, bundle(16'h0004, 0, 16'h0, 1, 3'd6, 1), 20'h0, 1'b1, "after_c1");
      apply_stimulus(3, bundle(16'h0004, 0, 16'h0, 1, 3'd6, 1), wb(16'h5555, 1, 3'd6), 1'b0, "after_c2");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
